lsu_ctrl: RTL and testbench

- Load/store unit: the initiator side of the word-wide data memory port.
- Accepts byte/half/word load and store requests from the execute stage and drives the memory's address, write-data and write-enable signals.
- Extracts and sign/zero-extends load data; performs read-modify-write for sub-word stores, because the memory is word-granular with no byte enables.
- Sits between the CPU pipeline and the data memory. Memory reads are combinational; writes commit on the falling clk edge while the write enable is high.

---
 rtl/lsu_pkg.sv | 65 ++++++
 rtl/lsu_lane_align.sv | 20 ++
 rtl/lsu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Request fields held for the duration of one access.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  // Pull the addressed lane(s) out of a word and sign/zero extend.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] sh_word;
    logic [31:0] result;
    sh_word = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: result = uns ? {24'h0, sh_word[7:0]}  : {{24{sh_word[7]}}, sh_word[7:0]};
      SZ_HALF: result = uns ? {16'h0, sh_word[15:0]} : {{16{sh_word[15]}}, sh_word[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  // Replace the addressed lane(s) of old_word with right-justified new_data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] mask;
    logic [4:0]  sh;
    case (size)
      SZ_BYTE: begin
        sh   = {off, 3'b000};
        mask = 32'h0000_00FF << sh;
      end
      SZ_HALF: begin
        sh   = {off[1], 4'b0000};
        mask = 32'h0000_FFFF << sh;
      end
      default: begin
        sh   = 5'd0;
        mask = 32'hFFFF_FFFF;
      end
    endcase
    return (old_word & ~mask) | ((new_data << sh) & mask);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extract (loads) and lane merge (sub-word stores).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ext_data_c,
  output logic [31:0] merge_data_c
);

  // Both paths evaluated in parallel; the controller picks by request type.
  always_comb begin
    ext_data_c   = lane_extract(rdata, off, size, uns);
    merge_data_c = lane_merge(rdata, wdata, off, size);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: word-granular memory port with read-modify-write
// for sub-word stores. Optional build macro LSU_MISALIGN_TRAP_EN turns
// misaligned half/word accesses into error responses instead of aligning them.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  logic              acc_err_c;
  logic [1:0]        acc_off_c;
  logic [31:0]       ext_data_c;
  logic [31:0]       merge_data_c;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_BITS+2];

  // Classify the incoming request: error detection and effective byte offset.
`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_c;
  always_comb begin
    misalign_c = ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    acc_err_c  = (req_size == SZ_ILL) || misalign_c;
    acc_off_c  = req_addr[1:0];
  end
`else
  always_comb begin
    acc_err_c = (req_size == SZ_ILL);
    case (req_size)
      SZ_HALF: acc_off_c = {req_addr[1], 1'b0};
      SZ_WORD: acc_off_c = 2'b00;
      default: acc_off_c = req_addr[1:0];
    endcase
  end
`endif

  lsu_lane_align u_align (
    .rdata        (mem_rdata),
    .wdata        (req_q.wdata),
    .off          (req_q.off),
    .size         (req_q.size),
    .uns          (req_q.uns),
    .ext_data_c   (ext_data_c),
    .merge_data_c (merge_data_c)
  );

  // Next-state and next-output logic; mem_we and resp_valid are single-cycle.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.write = req_write;
          req_d.size  = req_size;
          req_d.uns   = req_unsigned;
          req_d.off   = acc_off_c;
          req_d.wdata = req_wdata;
          req_ready_d = 1'b0;
          if (acc_err_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d     = WRITE;
            mem_addr_d  = 32'(req_addr[ADDR_BITS+1:2]);
            mem_wdata_d = req_wdata;
            mem_we_d    = 1'b1;
          end else begin
            state_d    = READ;
            mem_addr_d = 32'(req_addr[ADDR_BITS+1:2]);
          end
        end
      end
      READ: begin
        if (req_q.write) begin
          state_d     = WRITE;
          mem_wdata_d = merge_data_c;
          mem_we_d    = 1'b1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = ext_data_c;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      RESP: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-level reference memory, expected
// responses and writes queued at acceptance, checked by a negedge monitor.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.ADDR_BITS(8), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: combinational read, falling-edge write.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(negedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  // Reference memory as plain bytes.
  logic [7:0] ref_bytes [0:1023];

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_exp_t;

  typedef struct {
    int unsigned cyc;
    int unsigned idx;
    logic [31:0] data;
  } wr_exp_t;

  resp_exp_t   rq[$];
  wr_exp_t     wq[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // Reference model: expected effects of a request accepted in cycle t.
  task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int unsigned t);
    int unsigned n, ba, lat;
    logic [63:0] v;
    bit err;
    resp_exp_t r;
    wr_exp_t   w;
    err = (sz == 2'b11);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    if (!err && (addr % n) != 0) err = 1;
`endif
    ba = ((addr % 1024) / n) * n;
    if (err) begin
      r.cyc = t + 1; r.err = 1'b1; r.rdata = 32'h0;
      rq.push_back(r);
    end else if (!wr) begin
      v = 64'h0;
      for (int i = 0; i < int'(n); i++) v = v | (64'(ref_bytes[ba+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (~64'h0 << (8*n));
      r.cyc = t + 2; r.err = 1'b0; r.rdata = v[31:0];
      rq.push_back(r);
    end else begin
      for (int i = 0; i < int'(n); i++) ref_bytes[ba+i] = 8'((wd >> (8*i)) & 32'hFF);
      lat = (n == 4) ? 1 : 2;
      w.cyc = t + lat; w.idx = ba / 4; w.data = ref_word(ba / 4);
      wq.push_back(w);
      r.cyc = t + lat + 1; r.err = 1'b0; r.rdata = 32'h0;
      rq.push_back(r);
    end
  endtask

  // Present a request (valid left high) and return once it has been accepted.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, output int unsigned t);
    int k;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'h1);
    t = cyc;
    model(wr, sz, uns, addr, wd, t);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k;
    req_valid = 1'b0;
    k = 0;
    while ((rq.size() != 0 || wq.size() != 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_resp_queue", 32'(rq.size()), 32'h0);
    chk("drain_write_queue", 32'(wq.size()), 32'h0);
    idle_cycles(2);
  endtask

  // Monitor: every write and every response must match the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_mem_we", 32'(mem_we), 32'h0);
        end else begin
          wr_exp_t w;
          w = wq.pop_front();
          chk("we_cycle", 32'(cyc), 32'(w.cyc));
          chk("we_addr", mem_addr, 32'(w.idx));
          chk("we_data", mem_wdata, w.data);
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          resp_exp_t r;
          r = rq.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(r.cyc));
          chk("resp_err", 32'(resp_err), 32'(r.err));
          chk("resp_rdata", resp_rdata, r.rdata);
        end
      end
    end
  end

  initial begin
    int unsigned t0, t1, t2;
    logic [31:0] w, saved5, a;
    logic [1:0]  sz;
    int          nbad;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (i == 5) w = 32'h80FF7F01;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = 8'(w >> (8*b));
    end

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Extension cases on word 5.
    issue(1'b0, 2'b00, 1'b0, 32'h16, 32'h0, t0); idle_cycles(1);
    issue(1'b0, 2'b00, 1'b1, 32'h16, 32'h0, t0); idle_cycles(1);
    issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, t0); idle_cycles(1);
    issue(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, t0);
    drain();

    // Sub-word store then read back.
    issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h000000AA, t0);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, t0);
    drain();
    chk("mem5_after_sb", mem[5], 32'h80FFAA01);

    // Word store, half store, read back.
    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, t0);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, t0);
    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234, t0);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, t0);
    drain();
    chk("mem5_after_sh", mem[5], 32'h1234BEEF);

    // Misaligned word load and illegal size.
    issue(1'b0, 2'b10, 1'b0, 32'h16, 32'h0, t0);
    issue(1'b1, 2'b11, 1'b0, 32'h14, 32'h55555555, t0);
    issue(1'b0, 2'b11, 1'b1, 32'h14, 32'h0, t0);
    drain();

    // Reset during the read phase of a byte store: nothing may commit.
    saved5 = mem[5];
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_mem_we", 32'(mem_we), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(5);
    chk("midrst_mem5", mem[5], saved5);
    chk("midrst_ready_after", 32'(req_ready), 32'h1);

    // Held-valid back-to-back loads with a wrapping address.
    issue(1'b0, 2'b10, 1'b0, 32'h414, 32'h0, t0);
    issue(1'b0, 2'b00, 1'b1, 32'h417, 32'h0, t1);
    issue(1'b0, 2'b01, 1'b0, 32'h416, 32'h0, t2);
    drain();
    chk("b2b_second_accept", 32'(t1 - t0), 32'd3);
    chk("b2b_third_accept", 32'(t2 - t0), 32'd6);

    // Randomized traffic concentrated on a few words to exercise RMW.
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, t0);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(0, 3));
    end
    drain();

    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_word(i)) nbad++;
    chk("final_mem_mismatch_words", 32'(nbad), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
